dffmem_arbiter: RTL and testbench
=================================

Name: dffmem_arbiter

Overview:
- Sequencer and two-way round-robin arbiter that shares the single-port 8x16 DFF memory between two requesters, e.g. the host pin port and an internal engine.
- After reset it first clears every word to zero, then serves one read or write at a time.
- Each command uses a valid/ready handshake; completion is signalled by a one-cycle done pulse.
- Sits between the top-level I/O logic and the memory array.

Parameters:
- AW, 3, memory address width (DEPTH = 2**AW words).
- DW, 16, data width.
- INIT_CLEAR, 1, 1 = zero-fill all words after reset; 0 = go straight to IDLE.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0/req1  in  1  command valid, held until granted.
- we0/we1  in  1  1 = write, 0 = read.
- addr0/addr1  in  AW  word address.
- wdata0/wdata1  in  DW  write data.
- gnt0/gnt1  out  1  command accepted; combinational, only in IDLE.
- done0/done1  out  1  one-cycle completion pulse, registered.
- rdata  out  DW  read result, valid while done0 or done1 is high for a read.
- mem_adr  out  AW  memory address.
- mem_din  out  DW  memory write data.
- mem_we_n  out  1  memory write enable, active-low.
- mem_dout  in  DW  memory read data; registered, valid one cycle after mem_adr is presented.
- init_busy  out  1  zero-fill in progress.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset, applied at any time including mid-transaction:
  - state goes to INIT if INIT_CLEAR, otherwise IDLE.
  - Outputs: gnt*=0, done*=0, rdata=0, mem_adr=0, mem_din=0, mem_we_n=1, RR pointer favours req0.
  - A pending transaction is dropped; no done pulse is issued for it.
- INIT:
  - Counter cnt runs 0..DEPTH-1 with mem_adr=cnt, mem_din=0, mem_we_n=0.
  - Takes DEPTH cycles, then IDLE; init_busy=1 throughout.
  - req* is ignored and gnt* is held at 0.
- IDLE, in the same cycle T:
  - Only one requester: it is granted.
  - Both requesting: the one not granted last is granted (RR).
  - At most one of gnt0/gnt1 is high.
  - On req&gnt the arbiter latches we, addr, wdata and the requester id, moves to ISSUE, and flips the RR pointer.
- ISSUE (T+1):
  - mem_adr = latched addr, mem_din = latched wdata, mem_we_n = ~we.
  - Write: next state DONE.
  - Read: next state RDCAP.
- RDCAP (T+2, reads only): rdata <= mem_dout; next state DONE.
- DONE: done<id> = 1 for exactly one cycle; next state IDLE.
- Latency:
  - Write: done at T+2; the memory updates at the end of T+1.
  - Read: done at T+3.
  - Back-to-back throughput: write every 3 cycles, read every 4.
- mem_we_n is 0 only in INIT and in a write's ISSUE cycle.
- Outside ISSUE and INIT, mem_adr and mem_din hold their last values.
- rdata holds its value until the next read completes; writes leave it unchanged.
- A requester whose req stays high after gnt is treated as issuing a new command, served at the next IDLE subject to RR.
- Address wrap does not apply: addresses are full-range, and the INIT counter stops at DEPTH-1.

Decomposition:
- Package dffmem_arb_pkg:
  - state enum {INIT, IDLE, ISSUE, RDCAP, DONE}.
  - AW/DW defaults and DEPTH.
- Sub-module rr_arb2:
  - Inputs: req[1:0], pointer.
  - Output: one-hot grant.
  - Pointer update happens on accept.
- FSM, latches and memory drive live in dffmem_arbiter.

Test Plan:
- Reset, then hold rst=0 with INIT_CLEAR=1 -> init_busy high 8 cycles, mem_we_n=0 with mem_adr 0..7 and mem_din=0; read of addr 3 afterwards returns 16'h0000.
- req0 write addr 3, data 16'h1253, then req0 read addr 3 -> done0 at T+2 for the write; on the read, done0 at T+3 with rdata=16'h1253.
- req0 and req1 both held high with writes to addr 1 and 2 -> grant order 0,1,0,1 alternating; never two gnts in one cycle.
- req1 alone, read addr 7 after writing 16'hBEEF -> done1 only, rdata=16'hBEEF; done0 stays 0.
- rst asserted during ISSUE of a write to addr 5, data 16'hAAAA -> no done pulse, re-INIT runs, and addr 5 reads back 16'h0000.
- req0 held through INIT -> gnt0 first asserts in the first IDLE cycle, never earlier.

Source files
------------

// File: rtl/dffmem_arb_pkg.sv
// Shared types and defaults for the DFF memory sequencer/arbiter.
package dffmem_arb_pkg;

  localparam int unsigned AwDef    = 3;
  localparam int unsigned DwDef    = 16;
  localparam int unsigned DepthDef = 1 << AwDef;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StIssue,
    StRdcap,
    StDone
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; ptr = 0 favours req[0], ptr = 1 favours req[1].
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt    = 2'b00;
    gnt[0] = req[0] & (~ptr | ~req[1]);
    gnt[1] = req[1] & (ptr | ~req[0]);
  end

endmodule

// File: rtl/dffmem_arbiter.sv
// Sequencer sharing a single-port DFF memory between two requesters:
// zero-fills after reset, then serves one read or write at a time.
module dffmem_arbiter
  import dffmem_arb_pkg::*;
#(
  parameter int unsigned AW         = AwDef,
  parameter int unsigned DW         = DwDef,
  parameter bit          INIT_CLEAR = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we_n,
  input  logic [DW-1:0] mem_dout,
  output logic          init_busy,
  output logic          busy
);

  localparam int unsigned DEPTH = 1 << AW;

  state_e        state_q;
  logic [AW-1:0] cnt_q;
  logic [AW-1:0] adr_q;
  logic [DW-1:0] din_q;
  logic [DW-1:0] rdata_q;
  logic          we_n_q;
  logic          we_q;
  logic          id_q;
  logic          ptr_q;
  logic          done0_q;
  logic          done1_q;

  logic [1:0]    grant;
  logic          idle_act;
  logic          init_act;
  logic          accept;
  logic          accept_id;

  rr_arb2 u_rr_arb2 (
    .req (2'({req1, req0})),
    .ptr (ptr_q),
    .gnt (grant)
  );

  // Qualify with rst so every output reads its reset value while rst is high.
  assign idle_act  = (state_q == StIdle) && !rst;
  assign init_act  = (state_q == StInit) && !rst;
  assign gnt0      = idle_act & grant[0];
  assign gnt1      = idle_act & grant[1];
  assign accept    = gnt0 | gnt1;
  assign accept_id = gnt1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT_CLEAR ? StInit : StIdle;
      cnt_q   <= '0;
      adr_q   <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      we_n_q  <= 1'b1;
      we_q    <= 1'b0;
      id_q    <= 1'b0;
      ptr_q   <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      we_n_q  <= 1'b1;
      unique case (state_q)
        StInit: begin
          // Track the fill address so mem_adr holds DEPTH-1 once INIT ends.
          adr_q <= cnt_q;
          din_q <= '0;
          if (cnt_q == AW'(DEPTH - 1)) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StIdle: begin
          if (accept) begin
            id_q    <= accept_id;
            we_q    <= accept_id ? we1 : we0;
            adr_q   <= accept_id ? addr1 : addr0;
            din_q   <= accept_id ? wdata1 : wdata0;
            we_n_q  <= accept_id ? ~we1 : ~we0;
            // Next contest favours whoever was not just served.
            ptr_q   <= ~accept_id;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (we_q) begin
            done0_q <= ~id_q;
            done1_q <= id_q;
            state_q <= StDone;
          end else begin
            state_q <= StRdcap;
          end
        end
        StRdcap: begin
          rdata_q <= mem_dout;
          done0_q <= ~id_q;
          done1_q <= id_q;
          state_q <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    mem_adr  = adr_q;
    mem_din  = din_q;
    mem_we_n = we_n_q;
    if (rst) begin
      mem_adr  = '0;
      mem_din  = '0;
      mem_we_n = 1'b1;
    end else if (init_act) begin
      mem_adr  = cnt_q;
      mem_din  = '0;
      mem_we_n = 1'b0;
    end
  end

  assign done0     = done0_q;
  assign done1     = done1_q;
  assign rdata     = rdata_q;
  assign init_busy = init_act;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_dffmem_arbiter.sv
// Directed bench for dffmem_arbiter with a behavioural 8x16 registered-read memory.
module tb_dffmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [2:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1;
  logic [15:0] rdata;
  logic [2:0]  mem_adr;
  logic [15:0] mem_din;
  logic        mem_we_n;
  logic [15:0] mem_dout;
  logic        init_busy, busy;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [8];

  always #5 clk = ~clk;

  dffmem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .done0     (done0),
    .done1     (done1),
    .rdata     (rdata),
    .mem_adr   (mem_adr),
    .mem_din   (mem_din),
    .mem_we_n  (mem_we_n),
    .mem_dout  (mem_dout),
    .init_busy (init_busy),
    .busy      (busy)
  );

  // Single-port memory: write on edge when we_n low, read data registered.
  always @(posedge clk) begin
    if (!mem_we_n) mem[mem_adr] <= mem_din;
    mem_dout <= mem[mem_adr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one command, waits for its grant and done; lat counts cycles from T.
  task automatic issue(input int id, input logic w, input logic [2:0] a,
                       input logic [15:0] d, output int lat, output logic [15:0] rd,
                       output logic other);
    int waitc;
    waitc = 0;
    other = 1'b0;
    lat   = -1;
    rd    = 16'hxxxx;
    if (id == 0) begin
      req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
    end
    #1;
    while (!((id == 0) ? gnt0 : gnt1) && waitc < 50) begin
      tick;
      waitc++;
    end
    if (waitc >= 50) begin
      req0 = 1'b0;
      req1 = 1'b0;
      return;
    end
    tick;
    req0 = 1'b0;
    req1 = 1'b0;
    lat  = 1;
    while (!((id == 0) ? done0 : done1) && lat < 20) begin
      if ((id == 0) ? done1 : done0) other = 1'b1;
      tick;
      lat++;
    end
    if ((id == 0) ? done1 : done0) other = 1'b1;
    rd = rdata;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    total++;
    if ({gnt0, gnt1, done0, done1} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_handshake: got %b want 0000", {gnt0, gnt1, done0, done1});
    end
    total++;
    if (rdata !== 16'h0000) begin
      bad++;
      $display("FAIL reset_rdata: got %h want 0000", rdata);
    end
    total++;
    if ({mem_adr, mem_din, mem_we_n} !== {3'd0, 16'h0000, 1'b1}) begin
      bad++;
      $display("FAIL reset_mem: got adr=%0d din=%h we_n=%b want 0 0000 1",
               mem_adr, mem_din, mem_we_n);
    end
  endtask

  // req0 held across INIT: no grant before the first IDLE cycle, then read of addr 3 is zero.
  task automatic test_init;
    int lat;
    req0 = 1'b1; we0 = 1'b0; addr0 = 3'd3; wdata0 = 16'h0000;
    rst  = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({init_busy, mem_we_n, mem_adr, mem_din, gnt0} !== {1'b1, 1'b0, 3'(i), 16'h0, 1'b0}) begin
        bad++;
        $display("FAIL init_cycle%0d: got busy=%b we_n=%b adr=%0d din=%h gnt0=%b want 1 0 %0d 0000 0",
                 i, init_busy, mem_we_n, mem_adr, mem_din, gnt0, i);
      end
      tick;
    end
    total++;
    if ({init_busy, busy, gnt0, gnt1} !== 4'b0010) begin
      bad++;
      $display("FAIL init_first_idle: got init_busy=%b busy=%b gnt0=%b gnt1=%b want 0 0 1 0",
               init_busy, busy, gnt0, gnt1);
    end
    tick;
    req0 = 1'b0;
    lat  = 1;
    while (!done0 && lat < 20) begin
      tick;
      lat++;
    end
    total++;
    if (lat !== 3 || rdata !== 16'h0000) begin
      bad++;
      $display("FAIL init_readback: got lat=%0d rdata=%h want 3 0000", lat, rdata);
    end
  endtask

  task automatic test_write_read;
    int lat;
    logic [15:0] rd;
    logic other;
    issue(0, 1'b1, 3'd3, 16'h1253, lat, rd, other);
    total++;
    if (lat !== 2 || other !== 1'b0) begin
      bad++;
      $display("FAIL wr0_latency: got lat=%0d other=%b want 2 0", lat, other);
    end
    issue(0, 1'b0, 3'd3, 16'h0000, lat, rd, other);
    total++;
    if (lat !== 3 || rd !== 16'h1253) begin
      bad++;
      $display("FAIL rd0_addr3: got lat=%0d rdata=%h want 3 1253", lat, rd);
    end
    issue(0, 1'b1, 3'd4, 16'h5555, lat, rd, other);
    total++;
    if (lat !== 2 || rd !== 16'h1253) begin
      bad++;
      $display("FAIL wr_keeps_rdata: got lat=%0d rdata=%h want 2 1253", lat, rd);
    end
  endtask

  task automatic test_req1;
    int lat;
    logic [15:0] rd;
    logic other;
    issue(1, 1'b1, 3'd7, 16'hBEEF, lat, rd, other);
    total++;
    if (lat !== 2 || other !== 1'b0) begin
      bad++;
      $display("FAIL wr1_addr7: got lat=%0d done0_seen=%b want 2 0", lat, other);
    end
    issue(1, 1'b0, 3'd7, 16'h0000, lat, rd, other);
    total++;
    if (lat !== 3 || rd !== 16'hBEEF || other !== 1'b0) begin
      bad++;
      $display("FAIL rd1_addr7: got lat=%0d rdata=%h done0_seen=%b want 3 beef 0",
               lat, rd, other);
    end
  endtask

  // Both requesters held: grants alternate 0,1,0,1 every 3 cycles, never together.
  task automatic test_back_to_back;
    int order [4];
    int when [4];
    int n, cyc, lat;
    logic both;
    logic [15:0] rd;
    logic other;
    n = 0; cyc = 0; both = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 3'd1; wdata0 = 16'h1111;
    req1 = 1'b1; we1 = 1'b1; addr1 = 3'd2; wdata1 = 16'h2222;
    #1;
    while (n < 4 && cyc < 60) begin
      if (gnt0 && gnt1) both = 1'b1;
      if (gnt0) begin
        order[n] = 0; when[n] = cyc; n++;
      end else if (gnt1) begin
        order[n] = 1; when[n] = cyc; n++;
      end
      tick;
      cyc++;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    total++;
    if (n !== 4 || both !== 1'b0) begin
      bad++;
      $display("FAIL rr_grants: got count=%0d double=%b want 4 0", n, both);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (order[i] !== (i % 2)) begin
          bad++;
          $display("FAIL rr_order%0d: got requester %0d want %0d", i, order[i], i % 2);
        end
      end
      total++;
      if (when[1] - when[0] !== 3 || when[3] - when[2] !== 3) begin
        bad++;
        $display("FAIL rr_spacing: got %0d,%0d want 3,3",
                 when[1] - when[0], when[3] - when[2]);
      end
    end
    issue(0, 1'b0, 3'd1, 16'h0000, lat, rd, other);
    total++;
    if (rd !== 16'h1111) begin
      bad++;
      $display("FAIL rr_readback1: got %h want 1111", rd);
    end
    issue(1, 1'b0, 3'd2, 16'h0000, lat, rd, other);
    total++;
    if (rd !== 16'h2222) begin
      bad++;
      $display("FAIL rr_readback2: got %h want 2222", rd);
    end
  endtask

  // Reset during a write's ISSUE cycle drops it and reruns the zero-fill.
  task automatic test_reset_mid;
    int waitc, lat;
    logic seen_done;
    logic [15:0] rd;
    logic other;
    waitc = 0;
    seen_done = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 3'd5; wdata0 = 16'hAAAA;
    #1;
    while (!gnt0 && waitc < 50) begin
      tick;
      waitc++;
    end
    tick;
    req0 = 1'b0;
    rst  = 1'b1;
    #1;
    total++;
    if (mem_we_n !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_we_n: got %b want 1", mem_we_n);
    end
    tick;
    if (done0 || done1) seen_done = 1'b1;
    rst = 1'b0;
    #1;
    waitc = 0;
    while (init_busy && waitc < 30) begin
      if (done0 || done1) seen_done = 1'b1;
      tick;
      waitc++;
    end
    total++;
    if (waitc !== 8 || seen_done !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_reinit: got init_cycles=%0d done_seen=%b want 8 0",
               waitc, seen_done);
    end
    issue(0, 1'b0, 3'd5, 16'h0000, lat, rd, other);
    total++;
    if (lat !== 3 || rd !== 16'h0000) begin
      bad++;
      $display("FAIL rst_mid_addr5: got lat=%0d rdata=%h want 3 0000", lat, rd);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 16'hDEAD;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    test_reset;
    test_init;
    test_write_read;
    test_req1;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
